// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - control FSM for the 4-way set-associative data cache
// Sequences lookup, writeback, allocate and re-lookup; owns per-set tree PLRU.
module cache_ctrl #(
   parameter int NUM_SETS = 16,
   parameter int NUM_WAYS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [3:0]                  ufp_rmask,
   input  logic [3:0]                  ufp_wmask,
   input  logic [$clog2(NUM_SETS)-1:0] ufp_set,
   output logic                        ufp_resp,
   input  logic                        hit,
   input  logic [$clog2(NUM_WAYS)-1:0] hit_way,
   input  logic [NUM_WAYS-1:0]         valid_vec,
   input  logic [NUM_WAYS-1:0]         dirty_vec,
   output logic                        dfp_read,
   output logic                        dfp_write,
   input  logic                        dfp_resp,
   output logic                        req_latch,
   output logic                        mask_sel,
   output logic                        wdata_sel,
   output logic                        cache_sig_sel,
   output logic [$clog2(NUM_WAYS)-1:0] way_sel,
   output logic                        data_we,
   output logic                        tag_we,
   output logic                        valid_set,
   output logic                        dirty_wr,
   output logic                        dirty_val
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);

   typedef enum logic [2:0] {
      S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE, S_REREAD
   } state_t;

   state_t                      state_q, state_d;
   logic [NUM_SETS-1:0][2:0]    plru_q, plru_d;
   logic [WAY_W-1:0]            victim_q, victim_d;
   logic                        is_write_q, is_write_d;
   logic [SET_W-1:0]            set_q, set_d;

   logic [2:0]                  plru_cur, plru_upd;
   logic [WAY_W-1:0]            plru_victim, victim_c;
   logic                        found_invalid, needs_wb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         plru_q     <= '0;
         victim_q   <= '0;
         is_write_q <= 1'b0;
         set_q      <= '0;
      end else begin
         state_q    <= state_d;
         plru_q     <= plru_d;
         victim_q   <= victim_d;
         is_write_q <= is_write_d;
         set_q      <= set_d;
      end
   end

   // Tree PLRU: b0 picks the half, b1/b2 pick the way inside the low/high half.
   always_comb begin
      plru_cur    = plru_q[set_q];
      plru_victim = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
      plru_upd    = plru_cur;
      plru_upd[0] = ~hit_way[1];
      if (!hit_way[1]) plru_upd[1] = ~hit_way[0];
      else             plru_upd[2] = ~hit_way[0];
   end

   // Invalid ways are filled lowest-index first before PLRU is consulted.
   always_comb begin
      victim_c      = plru_victim;
      found_invalid = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!found_invalid && !valid_vec[w]) begin
            victim_c      = WAY_W'(w);
            found_invalid = 1'b1;
         end
      end
      needs_wb = valid_vec[victim_c] && dirty_vec[victim_c];
   end

   always_comb begin
      state_d       = state_q;
      plru_d        = plru_q;
      victim_d      = victim_q;
      is_write_d    = is_write_q;
      set_d         = set_q;
      ufp_resp      = 1'b0;
      dfp_read      = 1'b0;
      dfp_write     = 1'b0;
      req_latch     = 1'b0;
      mask_sel      = 1'b0;
      wdata_sel     = 1'b0;
      cache_sig_sel = 1'b0;
      way_sel       = '0;
      data_we       = 1'b0;
      tag_we        = 1'b0;
      valid_set     = 1'b0;
      dirty_wr      = 1'b0;
      dirty_val     = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               if ((ufp_rmask != 4'b0) || (ufp_wmask != 4'b0)) begin
                  req_latch  = 1'b1;
                  is_write_d = (ufp_wmask != 4'b0);
                  set_d      = ufp_set;
                  state_d    = S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (hit) begin
                  ufp_resp       = 1'b1;
                  way_sel        = hit_way;
                  plru_d[set_q]  = plru_upd;
                  if (is_write_q) begin
                     data_we   = 1'b1;
                     dirty_wr  = 1'b1;
                     dirty_val = 1'b1;
                  end
                  state_d = S_IDLE;
               end else begin
                  victim_d = victim_c;
                  state_d  = needs_wb ? S_WRITEBACK : S_ALLOCATE;
               end
            end
            S_WRITEBACK: begin
               dfp_write = 1'b1;
               way_sel   = victim_q;
               if (dfp_resp) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
               dfp_read = 1'b1;
               way_sel  = victim_q;
               if (dfp_resp) begin
                  data_we       = 1'b1;
                  tag_we        = 1'b1;
                  valid_set     = 1'b1;
                  dirty_wr      = 1'b1;
                  mask_sel      = 1'b1;
                  wdata_sel     = 1'b1;
                  cache_sig_sel = 1'b1;
                  state_d       = S_REREAD;
               end
            end
            S_REREAD: begin
               req_latch = 1'b1;
               state_d   = S_COMPARE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end
endmodule
